// File: rtl/spi_bus_monitor.sv
// Passive SPI bus monitor: reassembles MOSI/MISO words per chip select and
// flags protocol violations with sticky bits and saturating counters.
module spi_bus_monitor #(
    parameter logic CPOL       = 1'b0,
    parameter logic CPHA       = 1'b0,
    parameter int   DATA_WIDTH = 8,
    parameter logic MSB_FIRST  = 1'b1,
    parameter int   NUM_CS     = 4,
    parameter int   CNT_WIDTH  = 16,
    localparam int  CSW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic [NUM_CS-1:0]     cs_n,
    input  logic                  mosi,
    input  logic                  miso,
    input  logic                  miso_is_driven,
    input  logic                  clear,
    output logic                  frame_valid,
    output logic [CSW-1:0]        frame_cs,
    output logic [DATA_WIDTH-1:0] mosi_word,
    output logic [DATA_WIDTH-1:0] miso_word,
    output logic [6:0]            err_flags,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  word_count
);
    localparam int BCW = $clog2(DATA_WIDTH);
    localparam int LCW = $clog2(NUM_CS + 1);

    typedef enum logic [1:0] {SYNC, IDLE, ACTIVE} state_t;

    state_t                state;
    logic                  sclk_q, mosi_q;
    logic [NUM_CS-1:0]     cs_q;
    logic [BCW-1:0]        bit_cnt;
    logic [CSW-1:0]        cs_idx, low_idx;
    logic [LCW-1:0]        low_cnt;
    logic [DATA_WIDTH-1:0] mosi_sh, miso_sh, mosi_nxt, miso_nxt;
    logic                  rise, fall, samp_edge, chg_edge;
    logic                  cs_idle, cs_idle_q, one_low, multi_low;
    logic                  act, checking, last_bit, word_done;
    logic [6:0]            viol;

    assign rise      = sclk & ~sclk_q;
    assign fall      = ~sclk & sclk_q;
    assign samp_edge = (CPOL ^ CPHA) ? fall : rise;
    assign chg_edge  = (CPOL ^ CPHA) ? rise : fall;
    assign cs_idle   = &cs_n;
    assign cs_idle_q = &cs_q;

    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (!cs_n[i]) begin
                low_cnt = low_cnt + 1'b1;
                low_idx = CSW'(i);
            end
        end
    end

    assign one_low   = (low_cnt == LCW'(1));
    assign multi_low = (low_cnt > LCW'(1));

    if (MSB_FIRST) begin : g_msb
        assign mosi_nxt = {mosi_sh[DATA_WIDTH-2:0], mosi};
        assign miso_nxt = {miso_sh[DATA_WIDTH-2:0], miso};
    end else begin : g_lsb
        assign mosi_nxt = {mosi, mosi_sh[DATA_WIDTH-1:1]};
        assign miso_nxt = {miso, miso_sh[DATA_WIDTH-1:1]};
    end

    assign act       = (state == ACTIVE);
    assign checking  = (state != SYNC);
    assign last_bit  = (bit_cnt == BCW'(DATA_WIDTH - 1));
    assign word_done = act & ~cs_idle & samp_edge & last_bit;

    // Nothing is checked in SYNC: the bus may be mid-transfer after reset.
    assign viol[0] = checking & cs_idle & cs_idle_q & ((sclk != CPOL) | (sclk != sclk_q));
    assign viol[1] = act & samp_edge & (mosi != mosi_q);
    assign viol[2] = act & (mosi != mosi_q) & ~chg_edge;
    assign viol[3] = checking & miso_is_driven & cs_idle;
    assign viol[4] = checking & multi_low;
    assign viol[5] = act & one_low & (low_idx != cs_idx);
    assign viol[6] = act & cs_idle & (bit_cnt != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SYNC;
            sclk_q      <= CPOL;
            mosi_q      <= 1'b0;
            cs_q        <= '1;
            bit_cnt     <= '0;
            cs_idx      <= '0;
            mosi_sh     <= '0;
            miso_sh     <= '0;
            frame_valid <= 1'b0;
            frame_cs    <= '0;
            mosi_word   <= '0;
            miso_word   <= '0;
            err_flags   <= '0;
            err_count   <= '0;
            word_count  <= '0;
        end else begin
            sclk_q      <= sclk;
            mosi_q      <= mosi;
            cs_q        <= cs_n;
            frame_valid <= word_done;

            case (state)
                SYNC:   if (cs_idle) state <= IDLE;
                IDLE:   if (one_low) begin
                            state   <= ACTIVE;
                            cs_idx  <= low_idx;
                            bit_cnt <= '0;
                        end
                ACTIVE: if (cs_idle) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                        end else if (samp_edge) begin
                            // Keeps shifting through MULTI_CS / CS_SWITCH so no bits are lost.
                            mosi_sh <= mosi_nxt;
                            miso_sh <= miso_nxt;
                            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                        end
                default: state <= SYNC;
            endcase

            if (word_done) begin
                mosi_word <= mosi_nxt;
                miso_word <= miso_nxt;
                frame_cs  <= cs_idx;
            end

            if (clear) begin
                err_flags  <= viol;
                err_count  <= {{(CNT_WIDTH-1){1'b0}}, |viol};
                word_count <= {{(CNT_WIDTH-1){1'b0}}, word_done};
            end else begin
                err_flags <= err_flags | viol;
                if (|viol && !(&err_count))
                    err_count <= err_count + 1'b1;
                if (word_done && !(&word_count))
                    word_count <= word_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_bus_monitor.sv
// Bench for spi_bus_monitor: directed scenarios plus randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_spi_bus_monitor;
    localparam int DW   = 8;
    localparam int NCS  = 2;
    localparam int MAXC = 15;

    logic clk = 0, reset_n = 0, sclk0 = 0, sclk3 = 1;
    logic mosi = 0, miso = 0, mid = 0, clear = 0;
    logic [1:0] cs_n = 2'b11;

    logic       fv0, fcs0, fv3, fcs3;
    logic [7:0] mw0, sw0, mw3, sw3;
    logic [6:0] ef0, ef3;
    logic [3:0] ec0, wc0;
    logic [15:0] ec3, wc3;

    spi_bus_monitor #(.CPOL(1'b0), .CPHA(1'b0), .DATA_WIDTH(DW), .MSB_FIRST(1'b1),
                      .NUM_CS(NCS), .CNT_WIDTH(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .sclk(sclk0), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .miso_is_driven(mid), .clear(clear), .frame_valid(fv0), .frame_cs(fcs0),
        .mosi_word(mw0), .miso_word(sw0), .err_flags(ef0), .err_count(ec0), .word_count(wc0));

    spi_bus_monitor #(.CPOL(1'b1), .CPHA(1'b1), .DATA_WIDTH(DW), .MSB_FIRST(1'b1),
                      .NUM_CS(NCS), .CNT_WIDTH(16)) dut3 (
        .clk(clk), .reset_n(reset_n), .sclk(sclk3), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .miso_is_driven(mid), .clear(clear), .frame_valid(fv3), .frame_cs(fcs3),
        .mosi_word(mw3), .miso_word(sw3), .err_flags(ef3), .err_count(ec3), .word_count(wc3));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, fv0_cnt = 0, fv3_cnt = 0;

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model of dut0 (mode 0, MSB first) ----------------
    int         m_mode = 0;          // 0 sync, 1 idle, 2 in a frame
    int         m_rec = 0;
    logic [1:0] m_bits[$];           // {mosi,miso} samples of the word in progress
    logic       p_sclk = 0, p_mosi = 0, p_idle = 1;
    logic       exp_fv = 0, exp_cs = 0;
    logic [7:0] exp_mw = 0, exp_sw = 0;
    logic [6:0] exp_fl = 0;
    int         exp_ec = 0, exp_wc = 0;

    task automatic model_step();
        int nlow, idx;
        logic idle, samp, chg, done;
        logic [6:0] v;
        logic [7:0] mw, sw;
        nlow = 0; idx = 0; v = '0; done = 0; mw = '0; sw = '0;
        for (int i = 0; i < NCS; i++) if (!cs_n[i]) begin nlow++; idx = i; end
        idle = (nlow == 0);
        samp = sclk0 && !p_sclk;
        chg  = !sclk0 && p_sclk;
        if (m_mode != 0) begin
            if (idle && p_idle && (sclk0 != 1'b0 || sclk0 != p_sclk)) v[0] = 1;
            if (mid && idle) v[3] = 1;
            if (nlow > 1) v[4] = 1;
            if (m_mode == 2) begin
                if (samp && mosi != p_mosi) v[1] = 1;
                if (mosi != p_mosi && !chg) v[2] = 1;
                if (nlow == 1 && idx != m_rec) v[5] = 1;
                if (idle && m_bits.size() != 0) v[6] = 1;
            end
        end
        case (m_mode)
            0: if (idle) m_mode = 1;
            1: if (nlow == 1) begin m_mode = 2; m_rec = idx; m_bits.delete(); end
            default:
                if (idle) begin
                    m_mode = 1; m_bits.delete();
                end else if (samp) begin
                    m_bits.push_back({mosi, miso});
                    if (m_bits.size() == DW) begin
                        done = 1;
                        for (int i = 0; i < DW; i++) begin
                            mw[DW-1-i] = m_bits[i][1];
                            sw[DW-1-i] = m_bits[i][0];
                        end
                        m_bits.delete();
                    end
                end
        endcase
        exp_fv = done;
        if (done) begin exp_mw = mw; exp_sw = sw; exp_cs = (m_rec != 0); end
        if (clear) begin
            exp_fl = v; exp_ec = (v != 0) ? 1 : 0; exp_wc = done ? 1 : 0;
        end else begin
            exp_fl = exp_fl | v;
            if (v != 0 && exp_ec < MAXC) exp_ec++;
            if (done && exp_wc < MAXC) exp_wc++;
        end
        p_sclk = sclk0; p_mosi = mosi; p_idle = idle;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_rec = 0; m_bits.delete();
            p_sclk = 0; p_mosi = 0; p_idle = 1;
            exp_fv = 0; exp_cs = 0; exp_mw = 0; exp_sw = 0; exp_fl = 0; exp_ec = 0; exp_wc = 0;
        end else begin
            model_step();
        end
    end

    // compare process: every cycle, away from the clock edge
    always @(posedge clk) begin
        #2;
        cmp("frame_valid", fv0, exp_fv);
        cmp("frame_cs", fcs0, exp_cs);
        cmp("mosi_word", mw0, exp_mw);
        cmp("miso_word", sw0, exp_sw);
        cmp("err_flags", ef0, exp_fl);
        cmp("err_count", ec0, exp_ec);
        cmp("word_count", wc0, exp_wc);
        if (fv0) fv0_cnt++;
        if (fv3) fv3_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1; tick(1); clear = 0; tick(1);
    endtask

    task automatic start0(input int idx);
        cs_n = 2'b11; cs_n[idx] = 1'b0; mid = 1;
    endtask

    task automatic bit0(input logic mo, input logic mi, input int h);
        mosi = mo; miso = mi; sclk0 = 0; tick(h); sclk0 = 1; tick(h);
    endtask

    task automatic end0(input int h);
        sclk0 = 0; tick(h); cs_n = 2'b11; mid = 0; tick(h + 1);
    endtask

    task automatic word0(input logic [7:0] mo, input logic [7:0] mi, input int h);
        for (int b = DW - 1; b >= 0; b--) bit0(mo[b], mi[b], h);
    endtask

    task automatic bit3(input logic mo, input logic mi);
        mosi = mo; miso = mi; sclk3 = 0; tick(2); sclk3 = 1; tick(2);
    endtask

    int f0, f3;

    initial begin
        logic [7:0] a, b, m81, m7e, s18, se7;
        m81 = 8'h81; m7e = 8'h7E; s18 = 8'h18; se7 = 8'hE7;

        // reset state
        tick(3);
        cmp("rst frame_valid", fv0, 0);
        cmp("rst frame_cs", fcs0, 0);
        cmp("rst mosi_word", mw0, 0);
        cmp("rst err_flags", ef0, 0);
        cmp("rst err_count", ec0, 0);
        cmp("rst word_count", wc0, 0);
        reset_n = 1; tick(3);

        // mode 0 single word on cs 0
        f0 = fv0_cnt;
        start0(0); word0(8'hA5, 8'h3C, 2); end0(2);
        cmp("s1 pulses", fv0_cnt - f0, 1);
        cmp("s1 frame_cs", fcs0, 0);
        cmp("s1 mosi_word", mw0, 8'hA5);
        cmp("s1 miso_word", sw0, 8'h3C);
        cmp("s1 err_flags", ef0, 0);
        cmp("s1 model mosi", exp_mw, 8'hA5);

        // mode 3 back-to-back words on cs 1
        do_clear();
        f3 = fv3_cnt;
        cs_n = 2'b01; mid = 1;
        for (int i = DW - 1; i >= 0; i--) bit3(m81[i], s18[i]);
        for (int i = DW - 1; i >= 0; i--) bit3(m7e[i], se7[i]);
        tick(2); cs_n = 2'b11; mid = 0; tick(3);
        cmp("s2 pulses", fv3_cnt - f3, 2);
        cmp("s2 frame_cs", fcs3, 1);
        cmp("s2 word_count", wc3, 2);
        cmp("s2 mosi_word", mw3, 8'h7E);
        cmp("s2 miso_word", sw3, 8'hE7);
        cmp("s2 err_flags", ef3, 0);
        cmp("s2 err_count", ec3, 0);

        // partial word
        do_clear();
        f0 = fv0_cnt;
        start0(0);
        for (int i = 0; i < 5; i++) bit0(i[0], 1'b0, 2);
        end0(2);
        cmp("s3 err_flags", ef0, 7'b1000000);
        cmp("s3 err_count", ec0, 1);
        cmp("s3 pulses", fv0_cnt - f0, 0);

        // MOSI moves on the sampling edge, then clear
        do_clear();
        start0(0); mosi = 0; tick(2); sclk0 = 1; mosi = 1; tick(2); end0(2);
        cmp("s4 flag1", ef0[1], 1);
        do_clear();
        cmp("s4 cleared flags", ef0, 0);
        cmp("s4 cleared count", ec0, 0);

        // two chip selects for three cycles
        cs_n = 2'b00; tick(3); cs_n = 2'b11; tick(2);
        cmp("s5 err_flags", ef0, 7'b0010000);
        cmp("s5 err_count", ec0, 3);
        cmp("s5 model count", exp_ec, 3);

        // reset mid-transfer
        do_clear();
        f0 = fv0_cnt;
        start0(0);
        for (int i = 0; i < 4; i++) bit0(1'b1, 1'b0, 2);
        reset_n = 0; tick(2); reset_n = 1; tick(1);
        word0(8'h55, 8'h0F, 2); end0(2);
        cmp("s6 no pulse", fv0_cnt - f0, 0);
        cmp("s6 err_flags", ef0, 0);
        cmp("s6 err_count", ec0, 0);
        start0(0); word0(8'h55, 8'h0F, 2); end0(2);
        cmp("s6 pulse", fv0_cnt - f0, 1);
        cmp("s6 mosi_word", mw0, 8'h55);

        // randomized traffic against the model
        for (int t = 0; t < 160; t++) begin
            int k, h, nw, nb;
            k = $urandom_range(0, 11);
            h = $urandom_range(1, 3);
            if (k <= 6) begin
                nw = $urandom_range(1, 3);
                start0($urandom_range(0, 1));
                for (int w = 0; w < nw; w++) begin
                    a = 8'($urandom); b = 8'($urandom);
                    word0(a, b, h);
                end
                end0(h);
            end else if (k == 7) begin
                nb = $urandom_range(1, 7);
                start0($urandom_range(0, 1));
                for (int i = 0; i < nb; i++) bit0(1'($urandom), 1'($urandom), h);
                end0(h);
            end else if (k <= 9) begin
                for (int i = 0; i < 8; i++) begin
                    sclk0 = 1'($urandom); mosi = 1'($urandom); miso = 1'($urandom);
                    cs_n = 2'($urandom); mid = 1'($urandom);
                    if ($urandom_range(0, 9) == 0) clear = 1; else clear = 0;
                    tick(1);
                end
                clear = 0; cs_n = 2'b11; mid = 0; sclk0 = 0; tick(2);
            end else if (k == 10) begin
                do_clear();
            end else begin
                reset_n = 0; tick(1); reset_n = 1; tick(1);
            end
        end
        cs_n = 2'b11; mid = 0; sclk0 = 0; tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
